// File: rtl/instr_cache_set_param_pkg.sv
// Shared types and sizing helpers for the instruction-cache set and its LRU tracker.
package instr_cache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  function automatic int beats(input int b, input int fill_w);
    return (b * 8) / fill_w;
  endfunction

  function automatic int age_w(input int e);
    return (e > 1) ? $clog2(e) : 1;
  endfunction

endpackage

// File: rtl/instr_cache_set_param_if.sv
// Lookup and refill signals between the cache top (master) and one set (slave).
interface instr_cache_set_param_if #(
  parameter int B      = 64,
  parameter int TAG_W  = 26,
  parameter int FILL_W = 64
);
  logic                 active_set_i;
  logic                 ic_repl_grant_i;
  logic                 flush_i;
  logic [$clog2(B)-1:0] block_i;
  logic [TAG_W-1:0]     tag_i;
  logic [FILL_W-1:0]    rep_word_i;
  logic [31:0]          data_o;
  logic                 cache_set_miss_o;
  logic                 fill_done_o;

  modport master (
    output active_set_i, ic_repl_grant_i, flush_i, block_i, tag_i, rep_word_i,
    input  data_o, cache_set_miss_o, fill_done_o
  );

  modport slave (
    input  active_set_i, ic_repl_grant_i, flush_i, block_i, tag_i, rep_word_i,
    output data_o, cache_set_miss_o, fill_done_o
  );
endinterface

// File: rtl/instr_cache_set_param_lru.sv
// Age-based LRU for E ways: age 0 is most recent; victim prefers the lowest invalid way.
module cache_lru_age
  import instr_cache_pkg::*;
#(
  parameter  int E  = 4,
  localparam int AW = age_w(E)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 dflt_i,
  input  logic                 touch_i,
  input  logic [AW-1:0]        touch_way_i,
  input  logic [E-1:0]         valid_i,
  output logic [E-1:0][AW-1:0] ages_o,
  output logic [AW-1:0]        victim_o
);

  logic [E-1:0][AW-1:0] lru_q;
  logic [E-1:0][AW-1:0] lru_d;
  logic [AW-1:0]        touch_age;

  assign touch_age = lru_q[touch_way_i];

  // Only ways younger than the touched one age; older ways keep their slot.
  for (genvar gi = 0; gi < E; gi++) begin : g_age
    assign lru_d[gi] = dflt_i                       ? AW'(gi) :
                       !touch_i                     ? lru_q[gi] :
                       (touch_way_i == AW'(gi))     ? '0 :
                       (lru_q[gi] < touch_age)      ? lru_q[gi] + 1'b1 :
                                                      lru_q[gi];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < E; i++) lru_q[i] <= AW'(i);
    end else begin
      lru_q <= lru_d;
    end
  end

  always_comb begin
    victim_o = '0;
    for (int i = E - 1; i >= 0; i--) begin
      if (lru_q[i] == AW'(E - 1)) victim_o = AW'(i);
    end
    for (int i = E - 1; i >= 0; i--) begin
      if (!valid_i[i]) victim_o = AW'(i);
    end
  end

  assign ages_o = lru_q;

endmodule

// File: rtl/instr_cache_set_param.sv
// One instruction-cache set: E ways with tag/valid lookup, LRU replacement and a
// pausable, flushable refill engine that streams a block in FILL_W-bit beats.
module instr_cache_set_param
  import instr_cache_pkg::*;
#(
  parameter int B      = 64,
  parameter int E      = 4,
  parameter int TAG_W  = 26,
  parameter int FILL_W = 64
) (
  input logic                    clk_i,
  input logic                    reset_i,
  instr_cache_set_param_if.slave bus
);

  localparam int BEATS = beats(B, FILL_W);
  localparam int AW    = age_w(E);
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OW    = $clog2(B);
  localparam int WW    = OW - 2;

  fill_state_t       state_q;
  logic [CW-1:0]     cnt_q;
  logic [AW-1:0]     vict_q;
  logic [TAG_W-1:0]  ltag_q;
  logic [E-1:0]      valid_q;
  logic [TAG_W-1:0]  tag_q  [E];
  logic [FILL_W-1:0] data_q [E][BEATS];
  logic              fill_done_q;

  logic [E-1:0]         hit_vec;
  logic                 miss;
  logic [AW-1:0]        hit_way;
  logic [AW-1:0]        victim;
  logic [AW-1:0]        wr_way;
  logic [AW-1:0]        touch_way;
  logic [CW-1:0]        wr_beat;
  logic                 start;
  logic                 beat_wr;
  logic                 fill_last;
  logic                 touch;
  logic [B*8-1:0]       hit_blk;
  logic [WW-1:0]        word_idx;
  logic [E-1:0][AW-1:0] ages_unused;
  logic                 unused_lsb;

  // The victim's valid bit drops on fill entry, so a partial block can never hit.
  for (genvar gi = 0; gi < E; gi++) begin : g_hit
    assign hit_vec[gi] = bus.active_set_i && valid_q[gi] && (tag_q[gi] == bus.tag_i);
  end

  assign miss = ~|hit_vec;

  always_comb begin
    hit_way = '0;
    for (int i = E - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_way = AW'(i);
    end
  end

  always_comb begin
    hit_blk = '0;
    for (int k = 0; k < BEATS; k++) hit_blk[k*FILL_W +: FILL_W] = data_q[hit_way][k];
  end

  assign word_idx         = bus.block_i[OW-1:2];
  assign unused_lsb       = ^bus.block_i[1:0];
  assign bus.data_o       = miss ? 32'd0 : hit_blk[{word_idx, 5'b0} +: 32];
  assign bus.cache_set_miss_o = miss;
  assign bus.fill_done_o  = fill_done_q;

  assign start     = (state_q == IDLE) && bus.active_set_i && miss &&
                     bus.ic_repl_grant_i && !bus.flush_i;
  assign beat_wr   = start || ((state_q == FILL) && bus.active_set_i &&
                     bus.ic_repl_grant_i && !bus.flush_i);
  assign wr_way    = (state_q == IDLE) ? victim : vict_q;
  assign wr_beat   = (state_q == IDLE) ? '0 : cnt_q;
  assign fill_last = beat_wr && (wr_beat == CW'(BEATS - 1));
  assign touch     = fill_last ||
                     ((state_q == IDLE) && bus.active_set_i && !miss && !bus.flush_i);
  assign touch_way = fill_last ? wr_way : hit_way;

  cache_lru_age #(.E(E)) u_lru (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .dflt_i      (bus.flush_i),
    .touch_i     (touch),
    .touch_way_i (touch_way),
    .valid_i     (valid_q),
    .ages_o      (ages_unused),
    .victim_o    (victim)
  );

  always_ff @(posedge clk_i) begin
    if (beat_wr) data_q[wr_way][wr_beat] <= bus.rep_word_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || bus.flush_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      valid_q     <= '0;
      fill_done_q <= 1'b0;
    end else begin
      fill_done_q <= fill_last;
      case (state_q)
        IDLE: begin
          if (start) begin
            vict_q          <= victim;
            ltag_q          <= bus.tag_i;
            valid_q[victim] <= 1'b0;
            cnt_q           <= CW'(1);
            state_q         <= FILL;
            // Single-beat blocks complete on the entry edge.
            if (fill_last) begin
              valid_q[victim] <= 1'b1;
              tag_q[victim]   <= bus.tag_i;
              cnt_q           <= '0;
              state_q         <= IDLE;
            end
          end
        end
        FILL: begin
          if (beat_wr) begin
            cnt_q <= cnt_q + 1'b1;
            if (fill_last) begin
              valid_q[vict_q] <= 1'b1;
              tag_q[vict_q]   <= ltag_q;
              cnt_q           <= '0;
              state_q         <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_cache_set_param.sv
// Self-checking bench: default set against a behavioural model, plus an 8-way/32-byte set.
`timescale 1ns/1ps
module tb_instr_cache_set_param;

  localparam int B = 64, E = 4, TW = 26, FW = 64, BEATS = B * 8 / FW;
  localparam int B2 = 32, E2 = 8, FW2 = 32, BEATS2 = B2 * 8 / FW2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_cache_set_param_if #(.B(B),  .TAG_W(TW), .FILL_W(FW))  bus_a ();
  instr_cache_set_param_if #(.B(B2), .TAG_W(TW), .FILL_W(FW2)) bus_b ();

  instr_cache_set_param #(.B(B), .E(E), .TAG_W(TW), .FILL_W(FW)) dut_a (
    .clk_i(clk), .reset_i(rst), .bus(bus_a)
  );
  instr_cache_set_param #(.B(B2), .E(E2), .TAG_W(TW), .FILL_W(FW2)) dut_b (
    .clk_i(clk), .reset_i(rst), .bus(bus_b)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: contents as bytes, recency as an ordered list (front = most recent).
  logic          m_valid [E];
  logic [TW-1:0] m_tag   [E];
  logic [7:0]    m_bytes [E][B];
  int            m_order [$];
  bit            m_filling;
  int            m_vict;
  int            m_cnt;
  logic [TW-1:0] m_ltag;
  bit            m_done;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", name, obs, want);
    end
  endtask

  function automatic int m_age(input int w);
    foreach (m_order[k]) if (m_order[k] == w) return k;
    return -1;
  endfunction

  function automatic void m_touch(input int w);
    int p;
    p = m_age(w);
    m_order.delete(p);
    m_order.push_front(w);
  endfunction

  function automatic void m_default_order();
    m_order.delete();
    for (int i = 0; i < E; i++) m_order.push_back(i);
  endfunction

  function automatic int m_victim();
    for (int k = 0; k < E; k++) if (!m_valid[k]) return k;
    return m_order[E-1];
  endfunction

  function automatic int m_hit(input logic [TW-1:0] t);
    for (int k = 0; k < E; k++) if (m_valid[k] && m_tag[k] == t) return k;
    return -1;
  endfunction

  function automatic void m_reset();
    for (int k = 0; k < E; k++) m_valid[k] = 1'b0;
    m_default_order();
    m_filling = 0;
    m_cnt     = 0;
    m_done    = 0;
  endfunction

  // One clock of the default set: drive, check combinational outputs, advance model.
  task automatic cyc_a(input bit act, input bit grant, input bit flush,
                       input logic [5:0] blk, input logic [TW-1:0] tag);
    logic [63:0] word;
    logic [31:0] exp_d;
    int          hw;
    int          off;
    word = {$urandom, $urandom};
    bus_a.active_set_i    = act;
    bus_a.ic_repl_grant_i = grant;
    bus_a.flush_i         = flush;
    bus_a.block_i         = blk;
    bus_a.tag_i           = tag;
    bus_a.rep_word_i      = word;
    #1;
    hw    = act ? m_hit(tag) : -1;
    off   = int'({blk[5:2], 2'b00});
    exp_d = '0;
    if (hw >= 0) for (int k = 0; k < 4; k++) exp_d[k*8 +: 8] = m_bytes[hw][off + k];
    chk("miss", 64'(bus_a.cache_set_miss_o), 64'(hw < 0));
    chk("data", 64'(bus_a.data_o), 64'(exp_d));
    chk("fill_done", 64'(bus_a.fill_done_o), 64'(m_done));
    m_done = 0;
    if (flush) begin
      for (int k = 0; k < E; k++) m_valid[k] = 1'b0;
      m_default_order();
      m_filling = 0;
    end else if (act) begin
      if (!m_filling) begin
        if (hw >= 0) m_touch(hw);
        else if (grant) begin
          m_vict          = m_victim();
          m_ltag          = tag;
          m_valid[m_vict] = 1'b0;
          m_cnt           = 0;
          m_filling       = 1;
        end
      end else hw = -1;
      if (m_filling && grant) begin
        for (int k = 0; k < FW / 8; k++) m_bytes[m_vict][m_cnt*(FW/8) + k] = word[k*8 +: 8];
        m_cnt++;
        if (m_cnt == BEATS) begin
          m_valid[m_vict] = 1'b1;
          m_tag[m_vict]   = m_ltag;
          m_touch(m_vict);
          m_filling = 0;
          m_done    = 1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_ages_a(input string name, input int a0, input int a1, input int a2, input int a3);
    int want [E];
    want = '{a0, a1, a2, a3};
    for (int i = 0; i < E; i++) chk(name, 64'(dut_a.u_lru.ages_o[i]), 64'(want[i]));
  endtask

  task automatic set_b(input bit act, input bit grant, input logic [TW-1:0] tag,
                       input logic [31:0] word);
    bus_b.active_set_i    = act;
    bus_b.ic_repl_grant_i = grant;
    bus_b.flush_i         = 1'b0;
    bus_b.block_i         = '0;
    bus_b.tag_i           = tag;
    bus_b.rep_word_i      = word;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus_a.active_set_i = 0; bus_a.ic_repl_grant_i = 0; bus_a.flush_i = 0;
    bus_a.block_i = '0; bus_a.tag_i = '0; bus_a.rep_word_i = '0;
    set_b(0, 0, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_reset();

    // Reset state over ten idle cycles.
    repeat (10) cyc_a(0, 0, 0, 6'd0, '0);
    chk_ages_a("reset_ages", 0, 1, 2, 3);

    // Four complete fills, each followed by a hit on word 0.
    foreach (m_valid[f]) begin
      logic [TW-1:0] t;
      t = TW'(500 + 100 * f);
      repeat (BEATS) cyc_a(1, 1, 0, 6'd0, t);
      cyc_a(1, 0, 0, 6'd0, t);
    end
    chk_ages_a("ages_after_fills", 3, 2, 1, 0);

    // Read back newest to oldest at byte offset 4.
    for (int f = 3; f >= 0; f--) cyc_a(1, 0, 0, 6'd4, TW'(500 + 100 * f));
    chk_ages_a("ages_after_reads", 0, 1, 2, 3);

    // Refill with a three-cycle grant pause after beat 2: eleven cycles.
    repeat (3) cyc_a(1, 1, 0, 6'd0, TW'(1000));
    repeat (3) cyc_a(1, 0, 0, 6'd0, TW'(1000));
    repeat (5) cyc_a(1, 1, 0, 6'd0, TW'(1000));
    cyc_a(1, 0, 0, 6'd8, TW'(1000));
    chk_ages_a("ages_after_pause_fill", 1, 2, 3, 0);
    cyc_a(1, 0, 0, 6'd0, TW'(800));
    chk("tag800_evicted", 64'(bus_a.cache_set_miss_o), 64'(1));

    // Flush at beat 4 of a fill.
    repeat (4) cyc_a(1, 1, 0, 6'd0, TW'(1100));
    cyc_a(1, 1, 1, 6'd0, TW'(1100));
    chk_ages_a("ages_after_flush", 0, 1, 2, 3);
    foreach (m_valid[f]) cyc_a(1, 0, 0, 6'd0, TW'(500 + 100 * f));
    cyc_a(1, 0, 0, 6'd0, TW'(1000));
    cyc_a(1, 0, 0, 6'd0, TW'(1100));

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      cyc_a($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0,
            6'($urandom), TW'(500 + 100 * $urandom_range(0, 6)));
      for (int i = 0; i < E; i++) chk("rand_age", 64'(dut_a.u_lru.ages_o[i]), 64'(m_age(i)));
    end
    bus_a.active_set_i = 0;

    // 8-way, 32-byte, 32-bit-beat set: fill every way, then evict.
    for (int f = 0; f < E2; f++) begin
      for (int bt = 0; bt < BEATS2; bt++) begin
        set_b(1, 1, TW'(10 + f), 32'((f << 8) | bt));
        tick();
      end
      set_b(1, 0, TW'(10 + f), '0);
      chk("b_done", 64'(bus_b.fill_done_o), 64'(1));
      chk("b_hit", 64'(bus_b.cache_set_miss_o), 64'(0));
      chk("b_data", 64'(bus_b.data_o), 64'(f << 8));
      tick();
    end
    for (int i = 0; i < E2; i++) chk("b_ages", 64'(dut_b.u_lru.ages_o[i]), 64'(E2 - 1 - i));
    for (int bt = 0; bt < BEATS2; bt++) begin
      set_b(1, 1, TW'(99), 32'(32'hA0 + bt));
      tick();
    end
    set_b(1, 0, TW'(99), '0);
    chk("b9_done", 64'(bus_b.fill_done_o), 64'(1));
    chk("b9_data", 64'(bus_b.data_o), 64'(32'hA0));
    tick();
    chk("b9_way0_age", 64'(dut_b.u_lru.ages_o[0]), 64'(0));
    chk("b9_way1_age", 64'(dut_b.u_lru.ages_o[1]), 64'(7));
    set_b(1, 0, TW'(10), '0);
    chk("b9_evicted", 64'(bus_b.cache_set_miss_o), 64'(1));
    tick();
    set_b(1, 0, TW'(11), '0);
    chk("b9_kept", 64'(bus_b.cache_set_miss_o), 64'(0));
    tick();
    set_b(0, 0, '0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_cache_set_param.md
# instr_cache_set_param

Parametrised instruction-cache set: E ways of B-byte blocks with tag compare, per-way valid bits, age-based LRU and a fill engine that streams a block in over FILL_W-bit beats. The set sits below the instruction-cache top, which decodes the set index, drives `active_set_i` and arbitrates refills through `ic_repl_grant_i`. It generalises the fixed 4-way, 64-bit-fill set and adds three things that set lacks: explicit valid tracking, pausable fills and a whole-set flush.

## Interface
- `B`, 64: block size in bytes; power of two, ≥ 8.
- `E`, 4: associativity; power of two, ≥ 2.
- `TAG_W`, 26: tag width in bits.
- `FILL_W`, 64: fill beat width; power of two, 32..B*8. Derived `BEATS = B*8/FILL_W`.
- `clk_i`  in  1  clock.
- `reset_i`  in  1  reset; one clock, synchronous, active-high.
- `active_set_i`  in  1  this set is addressed this cycle.
- `ic_repl_grant_i`  in  1  refill beat valid / fill permitted.
- `flush_i`  in  1  invalidate the whole set.
- `block_i`  in  $clog2(B)  byte offset; bits [1:0] ignored.
- `tag_i`  in  TAG_W  lookup tag.
- `rep_word_i`  in  FILL_W  refill beat, lowest address first.
- `data_o`  out  32  word at `block_i` of the hit way; 0 on miss.
- `cache_set_miss_o`  out  1  no valid way matches `tag_i`, or set inactive.
- `fill_done_o`  out  1  one-cycle pulse after the final beat is written.

## Operation
- **Hit.** Combinational: some way has valid=1 and tag==`tag_i`, and `active_set_i`=1. `data_o` = block bytes [block_i&~3 +: 4], little-endian.
- **LRU ages.** Per-way age `lru_q[i]` in 0..E-1; 0 = most recent, E-1 = least recent.
- **Touch.** A hit (active, not filling, no flush) touches way w: ways with age < old age(w) increment, w becomes 0, others hold. Re-touching the age-0 way changes nothing.
- **Victim.** Lowest-index invalid way; if all are valid, the way with age E-1.
- **Fill FSM, IDLE → FILL.**
  - Trigger: active, miss and grant.
  - On entry: latch victim and `tag_i`, clear the victim's valid bit, write beat 0.
- **FILL.**
  - Each cycle with active & grant: write `rep_word_i` to beat slot `cnt_q`, then `cnt_q`++.
  - Grant or active low: pause, with counter, victim and tag held.
  - Beat BEATS-1 written: set valid, write latched tag, touch victim, pulse `fill_done_o`, return to IDLE.
- **Partial blocks.** The victim never hits mid-fill. `tag_i` changes during FILL are ignored; the latched tag is the one written.
- **Flush.** Next edge: all valid bits 0, ages reset to `lru_q[i]=i`, FSM to IDLE, counter 0. Flush beats fill and touch issued in the same cycle.
- **Inactive.** With `active_set_i`=0 there are no ages, valid, tag or data changes apart from flush.

## Timing
- **Reset.** valid=0, `lru_q[i]=i`, FSM IDLE, `cnt_q`=0, `fill_done_o`=0. Hence `cache_set_miss_o`=1 and `data_o`=0.
- **Lookup.** 0-cycle latency; the age update lands at the next edge.
- **Fill.**
  - BEATS granted cycles, with pauses adding cycles.
  - `fill_done_o` is high in the cycle after the last beat edge; the hit is visible in that same cycle.
- **Reset or flush mid-fill.** The fill is aborted and the victim stays invalid.
- **BEATS=1.** Entry and completion happen on the same edge.

## Structure
- Package `instr_cache_pkg`:
  - `fill_state_t` (IDLE, FILL).
  - Helper functions `beats(B, FILL_W)` and `age_w(E)`.
- Sub-module `cache_lru_age`:
  - Parametrised on E.
  - Inputs: touch valid, touch way, reset-to-default.
  - Outputs: ages and victim way, where the victim is the lowest-index invalid way if any, else the way with age E-1.
  - Reusable by the data-cache set.

## Test plan
- Reset, then 10 idle cycles → miss=1, `data_o`=0, `fill_done_o`=0, ages {0,1,2,3}.
- Default parameters; fill tags 500/600/700/800 with 8 beats each → `fill_done_o` pulses once per fill; each hit `data_o` equals bits [31:0] of its block; final ages {3,2,1,0}.
- Read tag 800, 700, 600, 500 at block 4 → each `data_o` equals that block's bytes 4..7; ages {0,1,2,3}.
- New tag 1000 fill with grant dropped for 3 cycles after beat 2 → miss until done, 11 cycles total; way 3 replaced; ages {1,2,3,0}; tag 800 now misses.
- Assert `flush_i` mid-fill at beat 4 → next cycle every tag misses, ages {0,1,2,3}, no `fill_done_o`.
- Rerun with E=8, B=32, FILL_W=32 → 8 beats per fill; filling all ways in order gives ages {7..0}; the ninth fill evicts way 0.
